// File: rtl/wvl_center_table_ctrl.sv
// Double-buffered resonator phase-center table: software fills the shadow bank,
// a commit arms a bank swap that lands on the next frame_sync.
module wvl_center_table_ctrl #(
  parameter int N_RES_BITS = 8,
  parameter int CENTER_W   = 16
) (
  input  logic                       user_clk,
  input  logic                       user_rst,
  input  logic [31:0]                ctrl_reg,
  input  logic [31:0]                data_reg,
  input  logic [N_RES_BITS-1:0]      res_idx,
  input  logic                       res_valid,
  input  logic                       frame_sync,
  output logic signed [CENTER_W-1:0] center_out,
  output logic                       center_valid,
  output logic [31:0]                status_out
);

  localparam int DEPTH = 1 << N_RES_BITS;
  localparam int AW    = N_RES_BITS + 1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic        wr_hist_q;
  logic        cm_hist_q;
  logic        wr_evt;
  logic        cm_evt;

  logic        active_q;
  logic [15:0] wr_cnt_q;
  logic [7:0]  swap_cnt_q;
  logic        err_q;
  logic [31:0] status_q;

  logic        wr_req;
  logic        wr_drop;
  logic        swap_now;
  logic        rd_bank;

  logic                       wr_en_p1;
  logic                       wr_bank_p1;
  logic [N_RES_BITS-1:0]      wr_addr_p1;
  logic signed [CENTER_W-1:0] wr_data_p1;

  logic                       vld_p1;
  logic signed [CENTER_W-1:0] rd_data_p1;
  logic                       vld_p2;
  logic signed [CENTER_W-1:0] center_p2;

  // Both banks live in one array; the MSB of the address selects the bank.
  logic signed [CENTER_W-1:0] mem [2*DEPTH];

  logic unused_ok;
  assign unused_ok = ^{ctrl_reg, data_reg};

  function automatic logic [31:0] pack_status(
    input logic [15:0] wcnt,
    input logic [7:0]  scnt,
    input logic        pend,
    input logic        err,
    input logic        bank
  );
    pack_status = {5'b0, bank, err, pend, scnt, wcnt};
  endfunction

  function automatic logic [AW-1:0] mem_addr(
    input logic                  bank,
    input logic [N_RES_BITS-1:0] idx
  );
    mem_addr = {bank, idx};
  endfunction

  assign wr_evt = ctrl_reg[31] ^ wr_hist_q;
  assign cm_evt = ctrl_reg[30] ^ cm_hist_q;

  // History follows ctrl_reg even in reset so release never looks like a toggle.
  always_ff @(posedge user_clk) begin
    wr_hist_q <= ctrl_reg[31];
    cm_hist_q <= ctrl_reg[30];
  end

  always_comb begin
    state_d  = state_q;
    wr_req   = 1'b0;
    wr_drop  = 1'b0;
    swap_now = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_req = wr_evt;
        if (cm_evt) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        wr_drop = wr_evt;
        if (frame_sync) begin
          swap_now = 1'b1;
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  // A lookup in the swap cycle already sees the new active bank.
  assign rd_bank = swap_now ? ~active_q : active_q;

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q    <= ST_IDLE;
      active_q   <= 1'b0;
      wr_cnt_q   <= '0;
      swap_cnt_q <= '0;
      err_q      <= 1'b0;
      status_q   <= '0;
      wr_en_p1   <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (swap_now) begin
        active_q   <= ~active_q;
        swap_cnt_q <= swap_cnt_q + 8'd1;
      end
      if (wr_en_p1) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      if (wr_drop) begin
        err_q <= 1'b1;
      end
      status_q <= pack_status(wr_cnt_q, swap_cnt_q, state_q == ST_PENDING,
                              err_q, active_q);
      wr_en_p1 <= wr_req;
      vld_p1   <= res_valid;
      vld_p2   <= vld_p1;
    end
  end

  // ---- stage p1: write capture and table read ----
  always_ff @(posedge user_clk) begin
    wr_bank_p1 <= ~active_q;
    wr_addr_p1 <= ctrl_reg[N_RES_BITS-1:0];
    wr_data_p1 <= data_reg[CENTER_W-1:0];
    rd_data_p1 <= mem[mem_addr(rd_bank, res_idx)];
    if (wr_en_p1 && !user_rst) begin
      mem[mem_addr(wr_bank_p1, wr_addr_p1)] <= wr_data_p1;
    end
  end

  // ---- stage p2: output register ----
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      center_p2 <= '0;
    end else begin
      center_p2 <= rd_data_p1;
    end
  end

  assign center_out   = center_p2;
  assign center_valid = vld_p2;
  assign status_out   = status_q;

endmodule

// File: tb/tb_wvl_center_table_ctrl.sv
// Directed bench for wvl_center_table_ctrl: writes, commits, swap timing,
// drop, reset abandon, streaming lookups and write-count wrap.
module tb_wvl_center_table_ctrl;

  logic        user_clk;
  logic        user_rst;
  logic [31:0] ctrl_reg;
  logic [31:0] data_reg;
  logic [7:0]  res_idx;
  logic        res_valid;
  logic        frame_sync;
  logic [15:0] center_out;
  logic        center_valid;
  logic [31:0] status_out;

  int n_cmp = 0;
  int n_err = 0;

  wvl_center_table_ctrl #(.N_RES_BITS(8), .CENTER_W(16)) dut (
    .user_clk     (user_clk),
    .user_rst     (user_rst),
    .ctrl_reg     (ctrl_reg),
    .data_reg     (data_reg),
    .res_idx      (res_idx),
    .res_valid    (res_valid),
    .frame_sync   (frame_sync),
    .center_out   (center_out),
    .center_valid (center_valid),
    .status_out   (status_out)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [15:0] val);
    ctrl_reg[31]  = ~ctrl_reg[31];
    ctrl_reg[7:0] = addr;
    data_reg      = {16'h0, val};
    tick();
  endtask

  task automatic do_commit();
    ctrl_reg[30] = ~ctrl_reg[30];
    tick();
  endtask

  task automatic pulse_fs();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    tick();
    tick();
  endtask

  task automatic lookup(input string tag, input logic [7:0] idx, input logic [15:0] exp);
    res_idx   = idx;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    tick();
    chk({tag, "_vld"}, {31'h0, center_valid}, 32'h1);
    chk(tag, {16'h0, center_out}, {16'h0, exp});
  endtask

  function automatic logic [15:0] pat(input int i);
    pat = 16'(i * 291 + 32768);
  endfunction

  initial begin
    int vcnt;
    user_rst   = 1'b1;
    ctrl_reg   = 32'h0;
    data_reg   = 32'h0;
    res_idx    = 8'h0;
    res_valid  = 1'b0;
    frame_sync = 1'b0;
    tick(); tick(); tick();

    // reset state
    chk("rst_status", status_out, 32'h0);
    chk("rst_cvld", {31'h0, center_valid}, 32'h0);
    chk("rst_cout", {16'h0, center_out}, 32'h0);
    user_rst = 1'b0;
    tick(); tick();
    chk("post_rst_status", status_out, 32'h0);

    // basic write / commit / swap
    do_write(8'd5, 16'h1234);
    do_write(8'd0, 16'h1111);
    tick(); tick();
    chk("wr2_status", status_out, 32'h0000_0002);
    do_commit();
    chk("pend_delay", status_out, 32'h0000_0002);
    tick();
    chk("pend_set", status_out, 32'h0100_0002);
    pulse_fs();
    chk("swap1_status", status_out, 32'h0401_0002);
    lookup("lk_idx5", 8'd5, 16'h1234);
    lookup("lk_idx0", 8'd0, 16'h1111);

    // swap timing: lookup in the frame_sync cycle sees the new bank
    do_write(8'd0, 16'h2222);
    do_commit();
    tick(); tick();
    res_idx    = 8'd0;
    res_valid  = 1'b1;
    tick();
    frame_sync = 1'b1;
    tick();
    chk("pre_swap_vld", {31'h0, center_valid}, 32'h1);
    chk("pre_swap_old", {16'h0, center_out}, 32'h1111);
    res_valid  = 1'b0;
    frame_sync = 1'b0;
    tick();
    chk("swap_cyc_vld", {31'h0, center_valid}, 32'h1);
    chk("swap_cyc_new", {16'h0, center_out}, 32'h2222);
    tick();
    chk("swap_idle_vld", {31'h0, center_valid}, 32'h0);
    chk("swap2_status", status_out, 32'h0002_0003);

    // write toggle while pending is dropped
    do_commit();
    tick();
    do_write(8'd5, 16'h5555);
    tick(); tick();
    chk("drop_status", status_out, 32'h0302_0003);
    pulse_fs();
    chk("drop_swap_status", status_out, 32'h0603_0003);
    lookup("drop_ram", 8'd5, 16'h1234);

    // simultaneous write + commit
    ctrl_reg[31]  = ~ctrl_reg[31];
    ctrl_reg[30]  = ~ctrl_reg[30];
    ctrl_reg[7:0] = 8'd7;
    data_reg      = 32'h0000_8001;
    tick(); tick(); tick();
    chk("both_status", status_out, 32'h0703_0004);
    pulse_fs();
    chk("both_swap_status", status_out, 32'h0204_0004);
    lookup("both_ram", 8'd7, 16'h8001);

    // commit coinciding with frame_sync in IDLE only arms the swap
    ctrl_reg[30] = ~ctrl_reg[30];
    frame_sync   = 1'b1;
    tick();
    frame_sync   = 1'b0;
    tick(); tick();
    chk("cm_fs_status", status_out, 32'h0304_0004);
    pulse_fs();
    chk("cm_fs_swap", status_out, 32'h0605_0004);

    // second commit while pending must not cause a second swap
    do_commit();
    do_commit();
    tick();
    pulse_fs();
    chk("dbl_commit", status_out, 32'h0206_0004);
    pulse_fs();
    chk("idle_fs", status_out, 32'h0206_0004);

    // reset abandons a pending commit
    do_commit();
    tick();
    ctrl_reg[31] = 1'b1;
    user_rst     = 1'b1;
    tick();
    chk("rst_mid_status", status_out, 32'h0);
    chk("rst_mid_cvld", {31'h0, center_valid}, 32'h0);
    chk("rst_mid_cout", {16'h0, center_out}, 32'h0);
    user_rst = 1'b0;
    pulse_fs();
    chk("rst_no_swap", status_out, 32'h0);

    // fill shadow bank, swap, then stream 256 lookups back to back
    for (int i = 0; i < 256; i++) do_write(8'(i), pat(i));
    do_commit();
    tick();
    pulse_fs();
    chk("fill_status", status_out, 32'h0401_0100);
    vcnt = 0;
    for (int i = 0; i < 258; i++) begin
      res_idx   = 8'(i);
      res_valid = (i < 256);
      tick();
      if (center_valid) vcnt++;
      if (i >= 1 && i <= 256) begin
        chk("stream", {15'h0, center_valid, center_out}, {15'h0, 1'b1, pat(i - 1)});
      end
    end
    res_valid = 1'b0;
    chk("stream_cnt", vcnt, 256);
    chk("stream_end_vld", {31'h0, center_valid}, 32'h0);

    // write count wraps 0xFFFF -> 0
    for (int k = 0; k < 65536 - 256 - 1; k++) do_write(8'(k), 16'h0);
    tick(); tick();
    chk("wcnt_ffff", status_out, 32'h0401_FFFF);
    do_write(8'd0, 16'h0);
    tick(); tick();
    chk("wcnt_wrap", status_out, 32'h0401_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
